seq_div_16: RTL and testbench

Sequential 16-bit unsigned restoring divider for the processor datapath. It is the inverse arithmetic path to the 16-bit ripple-carry adder. It reuses that adder in subtract mode (a + ~b + 1) once per cycle to produce a quotient and remainder over 16 iterations. The ALU or control unit drives it with a start/done handshake.

---
 rtl/seq_div_16_pkg.sv | 27 ++
 rtl/fa_16.sv | 29 ++
 rtl/seq_div_16.sv | 136 +++++++++++++
 tb/tb_seq_div_16.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/seq_div_16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_div_16_pkg
// Description : Shared constants and state encoding for the sequential
//               16-bit restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================

package seq_div_16_pkg;

    localparam int DIV_WIDTH = 16;
    localparam int DIV_STEPS = 16;

    localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = 16'hFFFF;

    // Count value seen at the edge that performs the final iteration.
    localparam logic [3:0] LAST_STEP = 4'(DIV_STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

endpackage

`default_nettype wire

// File: rtl/fa_16.sv
`default_nettype none
// ============================================================================
// Module      : fa_16
// Description : 16-bit ripple-carry adder built from a chain of full adders.
// Revision    : 1.0 - initial release
// ============================================================================

module fa_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [16:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < 16; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end

    assign cout = w_carry[16];

endmodule

`default_nettype wire

// File: rtl/seq_div_16.sv
`default_nettype none
// ============================================================================
// Module      : seq_div_16
// Description : Sequential 16-bit unsigned restoring divider, one quotient
//               bit per cycle through a shared subtract-mode ripple adder.
// Revision    : 1.0 - initial release
// ============================================================================

module seq_div_16
    import seq_div_16_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DIV_WIDTH-1:0] dividend,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic                 busy,
    output logic                 done,
    output logic [DIV_WIDTH-1:0] quotient,
    output logic [DIV_WIDTH-1:0] remainder,
    output logic                 div_by_zero
);

    div_state_t           r_state;
    div_state_t           w_next_state;

    logic [DIV_WIDTH-1:0] r_q;
    logic [DIV_WIDTH-1:0] r_d;
    // A restored remainder is always below D, so its 17th bit is identically
    // zero; only the low 16 bits are kept and the shifted value widens to 17.
    logic [DIV_WIDTH-1:0] r_rem;
    logic [3:0]           r_count;

    logic                 w_accept;
    logic                 w_zero_div;
    logic                 w_last;
    logic [DIV_WIDTH:0]   w_rs;
    logic [DIV_WIDTH-1:0] w_trial;
    logic                 w_cout;
    logic                 w_ge;
    logic [DIV_WIDTH-1:0] w_rem_next;
    logic [DIV_WIDTH-1:0] w_q_next;

    assign w_accept   = start && (r_state != S_RUN);
    assign w_zero_div = (divisor == '0);
    assign w_last     = (r_count == LAST_STEP);

    // ------------------------------------------------------------------
    // Iteration datapath: trial subtraction Rs - D as Rs + ~D + 1
    // ------------------------------------------------------------------
    assign w_rs = {r_rem, r_q[DIV_WIDTH-1]};

    fa_16 u_sub (
        .a    (w_rs[DIV_WIDTH-1:0]),
        .b    (~r_d),
        .cin  (1'b1),
        .sum  (w_trial),
        .cout (w_cout)
    );

    // A set Rs[16] means Rs >= 2^16 > D even though the 16-bit adder borrowed.
    assign w_ge       = w_rs[DIV_WIDTH] | w_cout;
    assign w_rem_next = w_ge ? w_trial : w_rs[DIV_WIDTH-1:0];
    assign w_q_next   = {r_q[DIV_WIDTH-2:0], w_ge};

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_next_state = w_zero_div ? S_DONE : S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

    // ------------------------------------------------------------------
    // Operand, iteration and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q         <= '0;
            r_d         <= '0;
            r_rem       <= '0;
            r_count     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (w_accept) begin
            if (w_zero_div) begin
                quotient    <= DBZ_QUOTIENT;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                r_q         <= dividend;
                r_d         <= divisor;
                r_rem       <= '0;
                r_count     <= '0;
                div_by_zero <= 1'b0;
            end
        end else if (r_state == S_RUN) begin
            r_q     <= w_q_next;
            r_rem   <= w_rem_next;
            r_count <= r_count + 4'd1;
            if (w_last) begin
                quotient  <= w_q_next;
                remainder <= w_rem_next;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_div_16.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_div_16
// Description : Self-checking bench for seq_div_16 against an arithmetic
//               reference (integer / and %) with directed and random operands.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_seq_div_16;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_div_16 dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands with start high across one rising edge, then scramble them.
    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
    endtask

    // Watch cycles T+1..T+latency after an accepted start, optionally firing a
    // stray start at cycle T+inject_k, then compare results to the reference.
    task automatic observe(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input int inject_k);
        int          lat;
        logic [17:0] bprof;
        logic [17:0] dprof;
        logic [17:0] bexp;
        logic [17:0] dexp;
        logic [15:0] eq;
        logic [15:0] er;
        bprof = '0;
        dprof = '0;
        bexp  = '0;
        dexp  = '0;
        if (b == 16'd0) begin
            lat = 1;
            eq  = 16'hFFFF;
            er  = a;
        end else begin
            lat = 17;
            eq  = a / b;
            er  = a % b;
            for (int k = 1; k <= 16; k++) bexp[k] = 1'b1;
        end
        dexp[lat] = 1'b1;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            bprof[k] = busy;
            dprof[k] = done;
            if (k == inject_k) begin
                start    = 1'b1;
                dividend = 16'd50;
                divisor  = 16'd5;
            end else if (k == inject_k + 1) begin
                start = 1'b0;
            end
        end
        check($sformatf("%s busy_profile", tag), 32'(bprof), 32'(bexp));
        check($sformatf("%s done_profile", tag), 32'(dprof), 32'(dexp));
        check($sformatf("%s quotient", tag), 32'(quotient), 32'(eq));
        check($sformatf("%s remainder", tag), 32'(remainder), 32'(er));
        check($sformatf("%s div_by_zero", tag), 32'(div_by_zero), 32'(b == 16'd0));
    endtask

    task automatic divide(input string tag, input logic [15:0] a, input logic [15:0] b);
        issue(a, b);
        observe(tag, a, b, 0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset quotient", 32'(quotient), 32'd0);
        check("reset remainder", 32'(remainder), 32'd0);
        check("reset div_by_zero", 32'(div_by_zero), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        divide("100/7", 16'd100, 16'd7);
        @(negedge clk);
        check("done_single_cycle", 32'(done), 32'd0);
        check("result_held", 32'(quotient), 32'd14);

        divide("FFFF/1", 16'hFFFF, 16'd1);
        divide("FFFF/FFFF", 16'hFFFF, 16'hFFFF);
        divide("8000/FFFF", 16'h8000, 16'hFFFF);
        divide("5/0", 16'd5, 16'd0);
        divide("9/3", 16'd9, 16'd3);

        issue(16'd3, 16'd10);
        observe("3/10 ignore_start", 16'd3, 16'd10, 5);
        @(negedge clk);
        check("ignored_start no_done", 32'(done), 32'd0);
        check("ignored_start no_busy", 32'(busy), 32'd0);

        // Second start presented during the DONE cycle of the first.
        issue(16'd1000, 16'd33);
        observe("b2b 1000/33", 16'd1000, 16'd33, 0);
        issue(16'd1234, 16'd10);
        observe("b2b 1234/10", 16'd1234, 16'd10, 0);

        issue(16'd60000, 16'd7);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrun_reset busy", 32'(busy), 32'd0);
        check("midrun_reset done", 32'(done), 32'd0);
        check("midrun_reset quotient", 32'(quotient), 32'd0);
        check("midrun_reset remainder", 32'(remainder), 32'd0);
        check("midrun_reset div_by_zero", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset idle", 32'({busy, done}), 32'd0);
        divide("20/6", 16'd20, 16'd6);

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = 16'd0;
                1, 2:    rb = 16'($urandom_range(1, 15));
                3:       rb = ra;
                default: rb = 16'($urandom);
            endcase
            divide($sformatf("rand%0d %0d/%0d", i, ra, rb), ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
